// File: rtl/noc_lsu_read_responder.sv
// Memory-side responder for NoC LSU read requests: decodes request packets, reads local memory,
// and returns a READRESP packet. Define NOC_LSU_BURST_EN to accept burst (multi-word) requests.
module noc_lsu_read_responder #(
  parameter int TILE_ID   = 0,
  parameter int MAX_BURST = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_flit,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_flit,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);
  localparam logic [2:0] CLASS_LSU    = 3'h2;
  localparam logic [2:0] MSG_READREQ  = 3'h0;
  localparam logic [2:0] MSG_READRESP = 3'h1;
  localparam logic [4:0] TILE         = 5'(TILE_ID);

  typedef enum logic [2:0] {
    S_HDR, S_ADDR, S_DROP, S_RSP_HDR, S_MEM, S_DATA
`ifdef NOC_LSU_BURST_EN
    , S_LEN
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [4:0]  src_reg, src_next;
  logic        size_reg, size_next;
  logic [31:0] out_flit_reg, out_flit_next;
  logic        in_ready_reg, out_valid_reg, out_last_reg, mem_req_reg, err_reg;
  logic        err_next, in_fire, hdr_bad, accept_next;
  logic        last_word, last_word_next;
  logic [31:0] resp_hdr;

  assign in_fire  = in_valid & in_ready_reg;
  assign resp_hdr = {src_reg, CLASS_LSU, TILE, MSG_READRESP, size_reg, 15'd0};

`ifdef NOC_LSU_BURST_EN
  localparam logic [5:0] MAX_N = 6'(MAX_BURST);
  logic [5:0] rem_reg, rem_next;
  logic [5:0] len_n;

  assign len_n          = in_flit[5:0];
  assign last_word      = (rem_reg == 6'd1);
  assign last_word_next = (rem_next == 6'd1);
  assign hdr_bad        = (in_flit[26:24] != CLASS_LSU) || (in_flit[18:16] != MSG_READREQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rem_reg <= '0;
    else        rem_reg <= rem_next;
  end
`else
  localparam int unused_max_burst = MAX_BURST;
  logic unused_addr_bits;

  assign unused_addr_bits = ^in_flit[1:0];
  assign last_word        = 1'b1;
  assign last_word_next   = 1'b1;
  // Without burst support a SIZE=1 header is just another unsupported packet.
  assign hdr_bad = (in_flit[26:24] != CLASS_LSU) || (in_flit[18:16] != MSG_READREQ) || in_flit[15];
`endif

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    src_next      = src_reg;
    size_next     = size_reg;
    out_flit_next = out_flit_reg;
    err_next      = 1'b0;
`ifdef NOC_LSU_BURST_EN
    rem_next      = rem_reg;
`endif
    case (state_reg)
      S_HDR: if (in_fire) begin
        if (hdr_bad) begin
          err_next   = 1'b1;
          state_next = in_last ? S_HDR : S_DROP;
        end else if (in_last) begin
          err_next = 1'b1;
        end else begin
          src_next   = in_flit[23:19];
          size_next  = in_flit[15];
          state_next = S_ADDR;
        end
      end
      S_ADDR: if (in_fire) begin
        addr_next = {in_flit[31:2], 2'b00};
        if (!size_reg) begin
          if (in_last) begin
            state_next    = S_RSP_HDR;
            out_flit_next = resp_hdr;
`ifdef NOC_LSU_BURST_EN
            rem_next      = 6'd1;
`endif
          end else begin
            err_next   = 1'b1;
            state_next = S_DROP;
          end
        end
`ifdef NOC_LSU_BURST_EN
        else if (in_last) begin
          err_next   = 1'b1;
          state_next = S_HDR;
        end else begin
          state_next = S_LEN;
        end
`endif
      end
`ifdef NOC_LSU_BURST_EN
      S_LEN: if (in_fire) begin
        if ((len_n == 6'd0) || (len_n > MAX_N)) begin
          err_next   = 1'b1;
          state_next = in_last ? S_HDR : S_DROP;
        end else if (!in_last) begin
          err_next   = 1'b1;
          state_next = S_DROP;
        end else begin
          rem_next      = len_n;
          state_next    = S_RSP_HDR;
          out_flit_next = resp_hdr;
        end
      end
`endif
      S_DROP: if (in_fire && in_last) state_next = S_HDR;
      S_RSP_HDR: if (out_ready) state_next = S_MEM;
      S_MEM: if (mem_ack) begin
        out_flit_next = mem_rdata;
        state_next    = S_DATA;
      end
      S_DATA: if (out_ready) begin
        addr_next  = addr_reg + 32'd4;
`ifdef NOC_LSU_BURST_EN
        rem_next   = rem_reg - 6'd1;
`endif
        state_next = last_word ? S_HDR : S_MEM;
      end
      default: state_next = S_HDR;
    endcase
  end

  assign accept_next = (state_next == S_HDR) || (state_next == S_ADDR) || (state_next == S_DROP)
`ifdef NOC_LSU_BURST_EN
                       || (state_next == S_LEN)
`endif
                       ;

  // Port-facing flags are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_HDR;
      addr_reg      <= '0;
      src_reg       <= '0;
      size_reg      <= 1'b0;
      out_flit_reg  <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      mem_req_reg   <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      src_reg       <= src_next;
      size_reg      <= size_next;
      out_flit_reg  <= out_flit_next;
      in_ready_reg  <= accept_next;
      out_valid_reg <= (state_next == S_RSP_HDR) || (state_next == S_DATA);
      out_last_reg  <= (state_next == S_DATA) && last_word_next;
      mem_req_reg   <= (state_next == S_MEM);
      err_reg       <= err_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_flit  = out_flit_reg;
  assign out_last  = out_last_reg;
  assign out_valid = out_valid_reg;
  assign mem_req   = mem_req_reg;
  assign mem_addr  = addr_reg;
  assign err       = err_reg;
endmodule
